ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//   Host-to-device PS/2 transmitter, the send side of the link the keyboard receiver listens on.
//   Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) per request: inhibits the bus,
//   issues a request-to-send, shifts 8 data bits + odd parity + stop on device-generated
//   clocks, checks the device ACK. Drives PS2_KBCLK/PS2_KBDAT through open-drain pull-low enables.
// PARAMETERS
//   INHIBIT_CYCLES  5000    Clk cycles the host holds psClk low before the start bit (100 us @ 50 MHz)
//   TIMEOUT_CYCLES  750000  max Clk cycles from clock release to ACK (15 ms @ 50 MHz)
//   CNT_W           20      width of the shared cycle counter; must hold both values above
// PORTS
//   Clk        in   1  system clock (CLOCK_50)
//   Reset_n    in   1  asynchronous, active-low reset
//   psClk_in   in   1  PS/2 clock pin level (asynchronous)
//   psData_in  in   1  PS/2 data pin level (asynchronous)
//   psClk_oe   out  1  1 = pull PS/2 clock low; 0 = release (pin is pulled up externally)
//   psData_oe  out  1  1 = pull PS/2 data low; 0 = release
//   tx_data    in   8  command byte to send
//   tx_valid   in   1  request; byte accepted on a cycle where tx_valid & tx_ready
//   tx_ready   out  1  1 only in IDLE
//   busy       out  1  1 in every state except IDLE
//   done       out  1  one-Clk pulse when a transfer ends (success, NACK or timeout)
//   ack_err    out  1  valid with done: 1 = device did not pull data low in the ACK slot
//   timeout    out  1  valid with done: 1 = TIMEOUT_CYCLES expired; ack_err is 0 then
// BEHAVIOUR
//   Reset (async, Reset_n=0): state IDLE, psClk_oe=0, psData_oe=0, tx_ready=1, busy=0,
//     done=0, ack_err=0, timeout=0, counters and shift register cleared. Reset asserted
//     mid-transfer releases both lines immediately (async); nothing is reported.
//   Input sync: psClk_in and psData_in each pass through a 2-flop synchronizer. A third
//     flop on clock gives fall = prev & ~cur. All protocol decisions use synced values only.
//   Accept: in IDLE with tx_valid=1, latch {parity=~^tx_data, tx_data}, clear counter,
//     go to INHIBIT on the next edge. Accepting aborts any device-to-host frame in progress,
//     per protocol.
//   FSM (one transition per Clk at most):
//     IDLE      -> INHIBIT on accept.
//     INHIBIT   psClk_oe=1. After INHIBIT_CYCLES cycles assert psData_oe=1 (start bit)
//               and go to RTS.
//     RTS       psData_oe=1, psClk_oe=0 (clock released). Counter restarts; it is the
//               timeout counter from here until ACK. Go to DATA; bit index=0.
//     DATA      on each fall: psData_oe = ~bit[index] (drive 0 bits low, release 1 bits);
//               after index 7 is driven go to PARITY.
//     PARITY    on fall: psData_oe = ~parity; go to STOP.
//     STOP      on fall: psData_oe=0 (stop=1); go to ACK.
//     ACK       on fall: sample synced data; ack_err = data (low = ACK); go to WAIT_IDLE.
//     WAIT_IDLE wait until synced clock=1 and data=1 together; then pulse done, go to IDLE.
//   Data changes only on falling clock edges, so it is stable across the device's rising-
//     edge sample. Bits are sent LSB first; parity is odd over the 8 data bits.
//   Timeout: in RTS..WAIT_IDLE, when the counter reaches TIMEOUT_CYCLES release both lines,
//     pulse done with timeout=1, ack_err=0, return to IDLE. Counter saturates; no wrap.
//   done, ack_err and timeout are registered; ack_err/timeout hold their last value
//     until the next done pulse. tx_ready returns to 1 the cycle after done.
//   tx_valid held high through done starts the next transfer straight from IDLE.
//   Falls seen in IDLE or INHIBIT are ignored; glitches shorter than two Clk cycles on
//     psClk_in are not guaranteed to be filtered.
// TESTING  (bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000; device model clocks ~40 Clk/half-period)
//   Send 0xED, device ACKs -> line bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done=1, ack_err=0, timeout=0
//   Send 0x01 -> 8 data bits 1,0,0,0,0,0,0,0 then parity 0; send 0xFF -> parity 1; both ACKed, ack_err=0
//   Device leaves data high in ACK slot for 0xF4 -> done=1, ack_err=1, timeout=0; lines released
//   Device never clocks after RTS -> done exactly 2000 cycles after clock release, timeout=1; both oe=0
//   Reset_n=0 after bit 3 of 0x55 -> psClk_oe=psData_oe=0 with no Clk edge; tx_ready=1 after release
//   INHIBIT phase check: psClk_oe=1 for exactly 20 cycles before psData_oe rises; tx_valid ignored while busy=1

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command-byte request/response bundle between a PS/2 host transmitter and its client.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_err, timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_err, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift 8 data + odd parity + stop
// on device clocks, then sample the device ACK. Lines are driven through open-drain pull-low enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         psClk_in,
    input  logic         psData_in,
    output logic         psClk_oe,
    output logic         psData_oe,
    ps2_host_tx_if.slave tx
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [8:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic             ack_q, ack_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       clk_sync_q, dat_sync_q;
    logic             clk_prev_q;
    logic             clk_s, dat_s, fall;

    // Synchronizers reset to the idle (released, high) bus level so no false fall follows reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], psClk_in};
            dat_sync_q <= {dat_sync_q[0], psData_in};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = clk_prev_q & ~clk_s;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            ack_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            ack_q     <= ack_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        ack_d     = ack_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (tx.tx_valid) begin
                    shift_d  = {~^tx.tx_data, tx.tx_data};
                    cnt_d    = '0;
                    idx_d    = '0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RTS;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RTS: begin
                // Release the clock; from here the counter measures the ACK timeout.
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                state_d  = S_DATA;
            end
            S_DATA: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    dat_oe_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[8:1]};
                    idx_d    = 3'(idx_q + 3'd1);
                    if (idx_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    dat_oe_d = ~shift_q[0];
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    dat_oe_d = 1'b0;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    ack_d   = dat_s;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = cnt_inc;
                if (clk_s && dat_s) begin
                    done_d    = 1'b1;
                    ack_err_d = ack_q;
                    timeout_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Device stalled somewhere between clock release and bus idle: give up and free the bus.
        if ((state_q inside {S_RTS, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE}) &&
            (cnt_q == TO_LAST)) begin
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b0;
            done_d    = 1'b1;
            ack_err_d = 1'b0;
            timeout_d = 1'b1;
            state_d   = S_IDLE;
        end
    end

    assign ready_d = (state_d == S_IDLE);
    assign busy_d  = (state_d != S_IDLE);

    assign psClk_oe    = clk_oe_q;
    assign psData_oe   = dat_oe_q;
    assign tx.tx_ready = ready_q;
    assign tx.busy     = busy_q;
    assign tx.done     = done_q;
    assign tx.ack_err  = ack_err_q;
    assign tx.timeout  = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a clocking device model, scoreboard on done.
module tb_ps2_host_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic psClk_oe, psData_oe, psClk_in, psData_in;

    // Wired-AND open-drain lines with external pull-ups.
    assign psClk_in  = dev_clk  & ~psClk_oe;
    assign psData_in = dev_data & ~psData_oe;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(2000),
        .CNT_W         (20)
    ) dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .psClk_in (psClk_in),
        .psData_in(psData_in),
        .psClk_oe (psClk_oe),
        .psData_oe(psData_oe),
        .tx       (bus)
    );

    typedef struct {
        logic [10:0] frame;
        logic        chk_frame;
        logic        ack_err;
        logic        timeout;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          dev_mode = 0;   // 0: ACK, 1: leave data high (NACK), 2: never clock
    logic [10:0] dev_frame = '0;
    int          dev_nbits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_ack_err"}, 32'(bus.ack_err), 32'(e.ack_err));
                check({e.name, "_timeout"}, 32'(bus.timeout), 32'(e.timeout));
                check({e.name, "_lines_released"}, 32'({psClk_oe, psData_oe}), 32'd0);
                if (e.chk_frame) check({e.name, "_frame"}, 32'(dev_frame), 32'(e.frame));
            end
            @(negedge clk);
            check("ready_after_done", 32'({bus.tx_ready, bus.busy, bus.done}), 32'b100);
        end
    end

    task automatic dev_half(output logic abort);
        repeat (40) @(negedge clk);
        abort = !rst_n;
    endtask

    // Device side of one host-to-device frame: 10 clocks reading bits on rising edges, then ACK.
    task automatic run_device();
        logic ab;
        dev_nbits = 0;
        dev_frame = '0;
        if (dev_mode == 2) begin
            while (bus.busy === 1'b1 && rst_n) @(negedge clk);
            return;
        end
        dev_half(ab);
        if (ab) return;
        dev_frame[0] = psData_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            dev_half(ab);
            dev_clk = 1'b1;
            if (ab) return;
            dev_frame[k] = psData_in;
            dev_nbits++;
            dev_half(ab);
            if (ab) return;
        end
        dev_data = (dev_mode == 1);
        dev_half(ab);
        if (ab) begin dev_data = 1'b1; return; end
        dev_clk = 1'b0;
        dev_half(ab);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        if (ab) return;
        while (bus.busy === 1'b1 && rst_n) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.busy === 1'b1 && psData_oe === 1'b1 && psClk_oe === 1'b0)
                run_device();
        end
    end

    task automatic send(input logic [7:0] d, input logic [10:0] frame, input logic ack_err,
                        input logic tmo, input logic chk_frame, input logic push,
                        input string name);
        exp_t e;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        if (push) begin
            e.frame = frame; e.chk_frame = chk_frame; e.ack_err = ack_err;
            e.timeout = tmo; e.name = name;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check({name, "_done_wait"}, 32'd0, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({psClk_oe, psData_oe, bus.tx_ready, bus.busy, bus.done, bus.ack_err, bus.timeout}),
              32'b0010000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 32'({bus.tx_ready, bus.busy, psClk_oe, psData_oe}), 32'b1000);

        // 0xED: data LSB first 1,0,1,1,0,1,1,1; parity 1; stop 1; start 0.
        dev_mode = 0;
        send(8'hED, 11'h7DA, 1'b0, 1'b0, 1'b1, 1'b1, "ed");
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (psData_oe === 1'b1) break;
            if (psClk_oe === 1'b1) n++;
        end
        check("inhibit_cycles", 32'(n), 32'd20);
        check("rts_clk_still_low", 32'(psClk_oe), 32'd1);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("busy_blocks_ready", 32'({bus.tx_ready, bus.busy}), 32'b01);
        bus.tx_valid = 1'b0;
        wait_done("ed");

        // 0x01: parity 0. 0xFF: parity 1.
        send(8'h01, 11'h402, 1'b0, 1'b0, 1'b1, 1'b1, "x01");
        wait_done("x01");
        send(8'hFF, 11'h7FE, 1'b0, 1'b0, 1'b1, 1'b1, "xff");
        wait_done("xff");

        // 0xF4 with data left high in the ACK slot.
        dev_mode = 1;
        send(8'hF4, 11'h5E8, 1'b1, 1'b0, 1'b1, 1'b1, "f4_nack");
        wait_done("f4_nack");

        // Silent device: done exactly 2000 cycles after the clock is released.
        dev_mode = 2;
        send(8'hED, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, "tmo");
        n = 0;
        while (psClk_oe !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (bus.done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        check("timeout_latency", 32'(n), 32'd2000);
        repeat (5) @(negedge clk);

        // Async reset during bit 3 of 0x55 (bit 3 is 0, so data is being pulled low).
        dev_mode  = 0;
        dev_nbits = 0;
        send(8'h55, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, "x55");
        n = 0;
        while (dev_nbits < 4 && n < 3000) begin @(negedge clk); n++; end
        #3;
        check("bit3_driven_low", 32'({psClk_oe, psData_oe}), 32'b01);
        rst_n = 1'b0;
        #1;
        check("async_reset_release", 32'({psClk_oe, psData_oe, bus.tx_ready, bus.busy}), 32'b0010);
        repeat (50) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'({bus.tx_ready, bus.busy, bus.done}), 32'b100);

        // Normal transfer still works after the aborted one.
        send(8'h01, 11'h402, 1'b0, 1'b0, 1'b1, 1'b1, "x01_post");
        wait_done("x01_post");

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
